// File: rtl/dual_prioenc_pkg.sv
// rtl/dual_prioenc_pkg.sv - shared widths and code values for the dual priority encoder
package dual_prioenc_pkg;

  // Default request vector width
  localparam int N = 12;

  // Default code width; 2^W must exceed N so that code N is representable
  localparam int W = 4;

  // Code value meaning "no such bit"
  localparam int CODE_NONE = 0;

endpackage

// File: rtl/dual_prioenc_prio_enc.sv
// rtl/dual_prioenc_prio_enc.sv - combinational encoder returning index+1 of the most-significant set bit
module prio_enc
  import dual_prioenc_pkg::*;
#(
  parameter int N = dual_prioenc_pkg::N,
  parameter int W = dual_prioenc_pkg::W
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] code
);

  // Scan upward so the highest set bit writes last and wins
  always_comb begin
    code = W'(CODE_NONE);
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        code = W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/dual_prioenc.sv
// rtl/dual_prioenc.sv - registered highest and second-highest request codes
module dual_prioenc
  import dual_prioenc_pkg::*;
#(
  parameter int N = dual_prioenc_pkg::N,
  parameter int W = dual_prioenc_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [W-1:0] first,
  output logic [W-1:0] second
);

  // Codes run up to N, so the code width must be able to hold it
  if ((2 ** W) <= N) begin : g_bad_width
    $error("dual_prioenc: W too small for N");
  end

  logic [W-1:0] first_c;
  logic [W-1:0] second_c;
  logic [N-1:0] masked;

  prio_enc #(.N(N), .W(W)) u_enc_first (
    .vec  (in),
    .code (first_c)
  );

  // Drop the bit chosen as first; nothing is cleared when first_c is "none"
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = in[i] && (first_c != W'(i + 1));
    end
  end

  prio_enc #(.N(N), .W(W)) u_enc_second (
    .vec  (masked),
    .code (second_c)
  );

  // Output registers; reset clears both codes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first  <= W'(CODE_NONE);
      second <= W'(CODE_NONE);
    end else begin
      first  <= first_c;
      second <= second_c;
    end
  end

endmodule

// File: tb/tb_dual_prioenc.sv
// tb/tb_dual_prioenc.sv - self-checking bench for dual_prioenc
module tb_dual_prioenc;
  import dual_prioenc_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic [W-1:0] first;
  logic [W-1:0] second;

  int vectors;
  int miscompares;

  dual_prioenc #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (in),
    .first  (first),
    .second (second)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk bits from the top and take the first two set positions
  function automatic void ref_model(input logic [N-1:0] v,
                                    output logic [W-1:0] f,
                                    output logic [W-1:0] s);
    int found;
    found = 0;
    f = '0;
    s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) begin
        if (found == 0) f = W'(k + 1);
        else if (found == 1) s = W'(k + 1);
        found++;
      end
    end
  endfunction

  // Drive on the falling edge, then sample 1 time unit after the rising edge
  task automatic apply(input logic [N-1:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (first !== 4'd0 || second !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got %0d,%0d want 0,0", first, second);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (first !== 4'd12 || second !== 4'd11) begin
      miscompares++;
      $display("FAIL reset_release: got %0d,%0d want 12,11", first, second);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] vals [8];
    logic [W-1:0] ef [8];
    logic [W-1:0] es [8];
    vals = '{12'h000, 12'h001, 12'h800, 12'h003, 12'hA00, 12'h801, 12'h0C7, 12'h0C0};
    ef   = '{4'd0, 4'd1, 4'd12, 4'd2, 4'd12, 4'd12, 4'd8, 4'd8};
    es   = '{4'd0, 4'd0, 4'd0,  4'd1, 4'd10, 4'd1,  4'd7, 4'd7};
    for (int i = 0; i < 8; i++) begin
      apply(vals[i]);
      vectors++;
      if (first !== ef[i] || second !== es[i]) begin
        miscompares++;
        $display("FAIL directed in=%h: got %0d,%0d want %0d,%0d",
                 vals[i], first, second, ef[i], es[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] f, s;
    for (int v = 0; v < (1 << N); v++) begin
      apply(N'(v));
      ref_model(N'(v), f, s);
      vectors++;
      if (first !== f || second !== s) begin
        miscompares++;
        $display("FAIL sweep in=%h: got %0d,%0d want %0d,%0d", N'(v), first, second, f, s);
      end
      vectors++;
      if ((second != 0) && ((first == 0) || (second >= first))) begin
        miscompares++;
        $display("FAIL invariant in=%h: got %0d,%0d want second<first", N'(v), first, second);
      end
      if (v == 2000) begin
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (first !== 4'd0 || second !== 4'd0) begin
          miscompares++;
          $display("FAIL midreset_async: got %0d,%0d want 0,0", first, second);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (first !== 4'd0 || second !== 4'd0) begin
          miscompares++;
          $display("FAIL midreset_hold: got %0d,%0d want 0,0", first, second);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] prev, cur;
    logic [W-1:0] pf, ps, f, s;
    prev = N'($urandom);
    apply(prev);
    ref_model(prev, pf, ps);
    for (int i = 0; i < 300; i++) begin
      cur = N'($urandom);
      ref_model(cur, f, s);
      @(negedge clk);
      in = cur;
      #1;
      vectors++;
      if (first !== pf || second !== ps) begin
        miscompares++;
        $display("FAIL latency in=%h: got %0d,%0d want %0d,%0d", cur, first, second, pf, ps);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (first !== f || second !== s) begin
        miscompares++;
        $display("FAIL random in=%h: got %0d,%0d want %0d,%0d", cur, first, second, f, s);
      end
      pf = f;
      ps = s;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in = '0;
    test_reset();
    test_directed();
    test_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
